// File: rtl/usb_tx_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : usb_tx_sequencer_if
// Description : Byte handshake between the packet builder (master) and the
//               USB transmit sequencer (slave). A byte moves on any cycle
//               where tx_valid and tx_ready are both high.
// Revision    : 1.0 - initial release
// ============================================================================
interface usb_tx_sequencer_if;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_last,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_last,
        input  tx_valid,
        output tx_ready
    );
endinterface
`default_nettype wire

// File: rtl/usb_tx_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : usb_tx_sequencer
// Description : Transmit-side controller for a USB-style differential line.
//               Gates the bit timer, and on each timer strobe emits one line
//               symbol: SYNC, NRZI-encoded bit-stuffed data, then EOP. Bytes
//               arrive through a one-byte holding buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_sequencer (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         strobe,
    output logic              timer_enable,
    usb_tx_sequencer_if.slave tx,
    output logic              dp_out,
    output logic              dm_out,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    localparam logic [7:0] c_SYNC        = 8'h80;
    localparam logic [2:0] c_STUFF_LIMIT = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_DATA  = 3'd2,
        S_STUFF = 3'd3,
        S_EOP   = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [2:0] r_bit_cnt,   w_bit_cnt_next;
    logic [2:0] r_ones_cnt,  w_ones_next;
    logic [1:0] r_eop_cnt,   w_eop_next;
    logic [7:0] r_shift,     w_shift_next;
    logic       r_cur_last,  w_cur_last_next;
    logic       r_underran,  w_underran_next;
    logic       r_dp,        w_dp_next;
    logic       r_dm,        w_dm_next;
    logic       r_done,      w_done_next;
    logic       r_underrun,  w_underrun_next;

    logic [7:0] r_buf_data;
    logic       r_buf_last;
    logic       r_buf_full;

    logic       w_load;
    logic       w_emit;
    logic       w_bit;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-strobe symbol selection; an emitted 0 toggles the
    // line (NRZI), an emitted 1 holds it.
    always_comb begin
        w_state_next    = r_state;
        w_bit_cnt_next  = r_bit_cnt;
        w_ones_next     = r_ones_cnt;
        w_eop_next      = r_eop_cnt;
        w_shift_next    = r_shift;
        w_cur_last_next = r_cur_last;
        w_underran_next = r_underran;
        w_dp_next       = r_dp;
        w_dm_next       = r_dm;
        w_done_next     = 1'b0;
        w_underrun_next = 1'b0;
        w_load          = 1'b0;
        w_emit          = 1'b0;
        w_bit           = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_dp_next = 1'b1;
                w_dm_next = 1'b0;
                if (r_buf_full) begin
                    w_state_next    = S_SYNC;
                    w_bit_cnt_next  = 3'd0;
                    w_ones_next     = 3'd0;
                    w_eop_next      = 2'd0;
                    w_cur_last_next = 1'b0;
                    w_underran_next = 1'b0;
                end
            end

            S_SYNC: begin
                if (strobe) begin
                    w_emit = 1'b1;
                    w_bit  = c_SYNC[r_bit_cnt];
                    if (r_bit_cnt == 3'd7) begin
                        // Sync ends in a 1, which counts toward stuffing.
                        w_ones_next    = 3'd1;
                        w_bit_cnt_next = 3'd0;
                        w_state_next   = S_DATA;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end
            end

            S_DATA: begin
                if (strobe) begin
                    if (r_ones_cnt == c_STUFF_LIMIT) begin
                        // Stuffed zero; the data bit position does not advance.
                        w_emit      = 1'b1;
                        w_bit       = 1'b0;
                        w_ones_next = 3'd0;
                    end else if (r_bit_cnt == 3'd0) begin
                        // Byte boundary: bit 0 of the next byte is needed now.
                        if (r_cur_last) begin
                            w_dp_next    = 1'b0;
                            w_dm_next    = 1'b0;
                            w_eop_next   = 2'd1;
                            w_state_next = S_EOP;
                        end else if (r_buf_full) begin
                            w_load          = 1'b1;
                            w_shift_next    = r_buf_data;
                            w_cur_last_next = r_buf_last;
                            w_emit          = 1'b1;
                            w_bit           = r_buf_data[0];
                            w_ones_next     = r_buf_data[0] ? (r_ones_cnt + 3'd1) : 3'd0;
                            w_bit_cnt_next  = 3'd1;
                        end else begin
                            w_dp_next       = 1'b0;
                            w_dm_next       = 1'b0;
                            w_eop_next      = 2'd1;
                            w_state_next    = S_EOP;
                            w_underrun_next = 1'b1;
                            w_underran_next = 1'b1;
                        end
                    end else begin
                        w_emit         = 1'b1;
                        w_bit          = r_shift[r_bit_cnt];
                        w_ones_next    = w_bit ? (r_ones_cnt + 3'd1) : 3'd0;
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                        // A stuff due right after the final bit goes out before EOP.
                        if ((r_bit_cnt == 3'd7) && r_cur_last && (w_ones_next == c_STUFF_LIMIT)) begin
                            w_state_next = S_STUFF;
                        end
                    end
                end
            end

            S_STUFF: begin
                if (strobe) begin
                    // Back to DATA at a boundary with the last byte done: next strobe starts EOP.
                    w_emit         = 1'b1;
                    w_bit          = 1'b0;
                    w_ones_next    = 3'd0;
                    w_bit_cnt_next = 3'd0;
                    w_state_next   = S_DATA;
                end
            end

            S_EOP: begin
                if (strobe) begin
                    if (r_eop_cnt == 2'd3) begin
                        w_dp_next    = 1'b1;
                        w_dm_next    = 1'b0;
                        w_eop_next   = 2'd0;
                        w_done_next  = ~r_underran;
                        w_state_next = S_IDLE;
                    end else if (r_eop_cnt == 2'd2) begin
                        w_dp_next  = 1'b1;
                        w_dm_next  = 1'b0;
                        w_eop_next = 2'd3;
                    end else begin
                        w_dp_next  = 1'b0;
                        w_dm_next  = 1'b0;
                        w_eop_next = 2'd2;
                    end
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (w_emit && !w_bit) begin
            w_dp_next = ~r_dp;
            w_dm_next = r_dp;
        end
    end

    // Serializer datapath and registered line/pulse outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt  <= 3'd0;
            r_ones_cnt <= 3'd0;
            r_eop_cnt  <= 2'd0;
            r_shift    <= 8'h00;
            r_cur_last <= 1'b0;
            r_underran <= 1'b0;
            r_dp       <= 1'b1;
            r_dm       <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_bit_cnt  <= w_bit_cnt_next;
            r_ones_cnt <= w_ones_next;
            r_eop_cnt  <= w_eop_next;
            r_shift    <= w_shift_next;
            r_cur_last <= w_cur_last_next;
            r_underran <= w_underran_next;
            r_dp       <= w_dp_next;
            r_dm       <= w_dm_next;
            r_done     <= w_done_next;
            r_underrun <= w_underrun_next;
        end
    end

    // One-byte holding buffer; accept and move never coincide since
    // tx_ready is low whenever the buffer is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_data <= 8'h00;
            r_buf_last <= 1'b0;
            r_buf_full <= 1'b0;
        end else if (w_load) begin
            r_buf_full <= 1'b0;
        end else if (tx.tx_valid && !r_buf_full) begin
            r_buf_data <= tx.tx_data;
            r_buf_last <= tx.tx_last;
            r_buf_full <= 1'b1;
        end
    end

    assign tx.tx_ready   = ~r_buf_full;
    assign timer_enable  = (r_state != S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign dp_out        = r_dp;
    assign dm_out        = r_dm;
    assign done          = r_done;
    assign underrun      = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_usb_tx_sequencer
// Description : Self-checking bench for usb_tx_sequencer. Each packet's
//               expected per-strobe line symbols and pulses are pushed into a
//               scoreboard queue and popped as the DUT emits them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_tx_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic strobe;
    logic timer_enable;
    logic dp_out;
    logic dm_out;
    logic busy;
    logic done;
    logic underrun;

    usb_tx_sequencer_if bus ();

    usb_tx_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .strobe       (strobe),
        .timer_enable (timer_enable),
        .tx           (bus),
        .dp_out       (dp_out),
        .dm_out       (dm_out),
        .busy         (busy),
        .done         (done),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Entry layout: {dp, dm, done, underrun, busy}
    logic [4:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: build raw bit stream (sync + data with a zero inserted after
    // every run of six ones), NRZI-encode from J, then append the EOP symbols.
    task automatic model_packet(input logic [31:0] data, input int n, input bit final_last);
        logic       bits[$];
        logic [7:0] v_sync;
        logic       b;
        logic       line;
        int         run;
        bit         ur;
        v_sync = 8'h80;
        run    = 0;
        line   = 1'b1;
        ur     = !final_last;
        for (int i = 0; i < 8; i++) begin
            bits.push_back(v_sync[i]);
            run = v_sync[i] ? run + 1 : 0;
        end
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 8; i++) begin
                b = data[8*k + i];
                bits.push_back(b);
                run = b ? run + 1 : 0;
                if (run == 6) begin
                    bits.push_back(1'b0);
                    run = 0;
                end
            end
        end
        foreach (bits[j]) begin
            if (!bits[j]) line = ~line;
            exp_q.push_back({line, ~line, 1'b0, 1'b0, 1'b1});
        end
        exp_q.push_back({2'b00, 1'b0, ur, 1'b1});
        exp_q.push_back({2'b00, 3'b001});
        exp_q.push_back({2'b10, 3'b001});
        exp_q.push_back({2'b10, !ur, 2'b00});
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        bit ok;
        ok = 0;
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_last  = l;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (bus.tx_ready) ok = 1;
            @(negedge clk);
        end
        bus.tx_valid = 1'b0;
        check("accept_in_time", ok, 1);
        check("tx_ready_drop", bus.tx_ready, 0);
        check("busy_not_yet", busy, 0);
    endtask

    // Runs one packet; later bytes are presented mid-way through the prior
    // byte, in the same cycle as a strobe. stop_after >= 0 truncates the run.
    task automatic run_packet(input logic [31:0] data, input int n, input bit final_last, input int stop_after);
        int         total;
        int         next_byte;
        logic [4:0] e;
        next_byte = 1;
        model_packet(data, n, final_last);
        total = exp_q.size();
        send_byte(data[7:0], (n == 1) && final_last);
        @(negedge clk);
        check("busy_rise", busy, 1);
        check("timer_enable_rise", timer_enable, 1);
        for (int s = 0; s < total && s != stop_after; s++) begin
            @(negedge clk);
            strobe = 1'b1;
            if (next_byte < n && s == 12 + 8*(next_byte - 1)) begin
                check("tx_ready_free", bus.tx_ready, 1);
                bus.tx_data  = data[8*next_byte +: 8];
                bus.tx_last  = (next_byte == n - 1) && final_last;
                bus.tx_valid = 1'b1;
                next_byte++;
            end
            @(negedge clk);
            strobe = 1'b0;
            if (bus.tx_valid) begin
                bus.tx_valid = 1'b0;
                check("tx_ready_after_accept", bus.tx_ready, 0);
            end
            e = exp_q.pop_front();
            check("line", {dp_out, dm_out}, e[4:3]);
            check("done", done, e[2]);
            check("underrun", underrun, e[1]);
            check("busy", busy, e[0]);
            @(negedge clk);
            @(negedge clk);
            check("line_hold", {dp_out, dm_out}, e[4:3]);
            check("pulse_clear", {done, underrun}, 2'b00);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        strobe       = 1'b0;
        bus.tx_data  = 8'h00;
        bus.tx_last  = 1'b0;
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_line", {dp_out, dm_out}, 2'b10);
        check("rst_timer_enable", timer_enable, 0);
        check("rst_tx_ready", bus.tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_underrun", underrun, 0);
        rst = 1'b0;
        @(negedge clk);

        run_packet(32'h0000_00FF, 1, 1'b1, -1);   // stuffing inside a byte
        run_packet(32'h0000_0000, 1, 1'b1, -1);   // all zeros, no stuff
        run_packet(32'h0000_3CA5, 2, 1'b1, -1);   // A5 then 3C, late second byte
        run_packet(32'h0000_0012, 1, 1'b0, -1);   // underrun
        run_packet(32'h0000_07E0, 2, 1'b1, -1);   // ones run across bytes
        run_packet(32'h0000_00FC, 1, 1'b1, -1);   // stuff after final bit

        // Reset during the first EOP SE0 symbol.
        run_packet(32'h0000_00FF, 1, 1'b1, 18);
        check("pre_reset_se0", {dp_out, dm_out}, 2'b00);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_line", {dp_out, dm_out}, 2'b10);
        check("midrst_timer_enable", timer_enable, 0);
        check("midrst_busy", busy, 0);
        check("midrst_tx_ready", bus.tx_ready, 1);
        check("midrst_done", done, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            strobe = (i % 3 == 0);
            if (done) pulses++;
        end
        strobe = 1'b0;
        check("no_done_after_reset", pulses, 0);
        check("idle_after_reset", busy, 0);

        run_packet(32'h0000_005A, 1, 1'b1, -1);   // recovery after reset

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
